// File: rtl/truth_table_bist.sv
// truth_table_bist: sweeps every input vector into a combinational DUT and checks Y against a truth table
module truth_table_bist #(
  parameter int                     N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0]   EXPECT = 8'b0010_0100,
  parameter int                     SETTLE = 1
) (
  input  logic            CLK,
  input  logic            N_RESET,
  input  logic            START,
  input  logic            Y,
  output logic [N_IN-1:0] X,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   FAIL_COUNT,
  output logic            FAIL_VALID,
  output logic [N_IN-1:0] FIRST_FAIL
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FIN} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] x_q, x_d, ffirst_q, ffirst_d;
  logic [N_IN:0] fcnt_q, fcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fvalid_q, fvalid_d, mis;
  assign mis = Y != EXPECT[x_q];
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fcnt_d   = fcnt_q;
    fvalid_d = fvalid_q;
    ffirst_d = ffirst_q;
    case (state_q)
      IDLE, FIN: if (START) begin
        state_d  = APPLY;
        x_d      = '0;
        cnt_d    = '0;
        fcnt_d   = '0;
        fvalid_d = 1'b0;
        ffirst_d = '0;
        pass_d   = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
      end
      APPLY: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(SETTLE - 1) ? SAMPLE : APPLY;
      end
      SAMPLE: begin
        if (mis) begin
          fcnt_d = fcnt_q + 1'b1;
          if (!fvalid_q) begin
            ffirst_d = x_q;
            fvalid_d = 1'b1;
          end
        end
        if (x_q != '1) begin
          x_d     = x_q + 1'b1;
          cnt_d   = '0;
          state_d = APPLY;
        end else begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = fcnt_d == '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q  <= IDLE;
      x_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fcnt_q   <= '0;
      fvalid_q <= 1'b0;
      ffirst_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fcnt_q   <= fcnt_d;
      fvalid_q <= fvalid_d;
      ffirst_q <= ffirst_d;
    end
  end
  assign X          = x_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign FAIL_COUNT = fcnt_q;
  assign FAIL_VALID = fvalid_q;
  assign FIRST_FAIL = ffirst_q;
endmodule

// File: tb/tb_truth_table_bist.sv
// tb_truth_table_bist: table-driven sweeps on two BIST instances (SETTLE=1 and SETTLE=3)
module tb_truth_table_bist;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, y0, y1;
  logic [2:0] x0, x1, ff0, ff1;
  logic [3:0] fc0, fc1;
  logic busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  int mode0 = 0, mode1 = 0, n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  function automatic logic model_y(input int m, input logic [2:0] v);
    logic e;
    e = (v == 3'd2) || (v == 3'd5);
    return m == 0 ? e : m == 1 ? 1'b0 : m == 2 ? !e : 1'b1;
  endfunction
  always_comb y0 = model_y(mode0, x0);
  always_comb y1 = model_y(mode1, x1);

  truth_table_bist u0 (.CLK(clk), .N_RESET(rst_n), .START(start0), .Y(y0), .X(x0), .BUSY(busy0),
    .DONE(done0), .PASS(pass0), .FAIL_COUNT(fc0), .FAIL_VALID(fv0), .FIRST_FAIL(ff0));
  truth_table_bist #(.SETTLE(3)) u1 (.CLK(clk), .N_RESET(rst_n), .START(start1), .Y(y1), .X(x1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_COUNT(fc1), .FAIL_VALID(fv1), .FIRST_FAIL(ff1));

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, " X"}, int'(x0), 0);
    check({nm, " BUSY"}, int'(busy0), 0);
    check({nm, " DONE"}, int'(done0), 0);
    check({nm, " PASS"}, int'(pass0), 0);
    check({nm, " FAIL_COUNT"}, int'(fc0), 0);
    check({nm, " FAIL_VALID"}, int'(fv0), 0);
    check({nm, " FIRST_FAIL"}, int'(ff0), 0);
  endtask

  typedef struct {
    int   sel;
    int   mode;
    int   cnt;
    int   first;
    logic pass;
    logic hold;
  } vec_t;

  task automatic sweep(input vec_t v, input string nm);
    logic [2:0] xq[$];
    int s, n;
    s = v.sel ? 3 : 1;
    n = (s + 1) * 8;
    @(negedge clk);
    if (v.sel) begin mode1 = v.mode; start1 = 1'b1; end
    else begin mode0 = v.mode; start0 = 1'b1; end
    for (int c = 0; c < n; c++) xq.push_back(3'(c / (s + 1)));
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check({nm, " X"}, int'(v.sel ? x1 : x0), int'(xq.pop_front()));
      check({nm, " BUSY"}, int'(v.sel ? busy1 : busy0), 1);
      check({nm, " DONE"}, int'(v.sel ? done1 : done0), 0);
      if (c == 0) begin
        check({nm, " cleared FAIL_COUNT"}, int'(v.sel ? fc1 : fc0), 0);
        check({nm, " cleared FAIL_VALID"}, int'(v.sel ? fv1 : fv0), 0);
        check({nm, " cleared PASS"}, int'(v.sel ? pass1 : pass0), 0);
      end
      if (c == (v.hold ? n - 1 : 0)) begin start0 = 1'b0; start1 = 1'b0; end
      else if (v.hold) begin start0 = !v.sel; start1 = v.sel; end
    end
    @(negedge clk);
    check({nm, " end DONE"}, int'(v.sel ? done1 : done0), 1);
    check({nm, " end BUSY"}, int'(v.sel ? busy1 : busy0), 0);
    check({nm, " end PASS"}, int'(v.sel ? pass1 : pass0), int'(v.pass));
    check({nm, " end FAIL_COUNT"}, int'(v.sel ? fc1 : fc0), v.cnt);
    check({nm, " end FAIL_VALID"}, int'(v.sel ? fv1 : fv0), int'(v.cnt != 0));
    if (v.cnt != 0) check({nm, " end FIRST_FAIL"}, int'(v.sel ? ff1 : ff0), v.first);
    check({nm, " end X held"}, int'(v.sel ? x1 : x0), 7);
    @(negedge clk);
    check({nm, " DONE holds"}, int'(v.sel ? done1 : done0), 1);
  endtask

  initial begin
    vec_t tbl[6];
    bit hit;
    tbl[0] = '{0, 0, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{0, 1, 2, 2, 1'b0, 1'b0};
    tbl[2] = '{0, 2, 8, 0, 1'b0, 1'b0};
    tbl[3] = '{1, 0, 0, 0, 1'b1, 1'b0};
    tbl[4] = '{0, 3, 6, 0, 1'b0, 1'b0};
    tbl[5] = '{0, 0, 0, 0, 1'b1, 1'b1};
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");
    for (int i = 0; i < 6; i++) sweep(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = x0 == 3'd4;
    end
    check("reach X=4", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk);
    check_zero("reset held");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle after reset");
    sweep(tbl[0], "post-reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_bist.md
# truth_table_bist

Hardware self-test sequencer for small combinational blocks such as the 3-input signal-manipulation exercises. It drives every input vector 0 … 2^N_IN−1 into the device under test and samples the DUT output after a programmable settle time. Each sample is compared against a parameterised truth table, and the block reports pass/fail, the failure count and the first failing vector. It sits beside the DUT in synthesised designs, replacing the simulation-only bench with on-chip checking.

## Interface
- N_IN, default 3: number of DUT inputs; legal range 1–6.
- EXPECT, default 8'b0010_0100: expected truth table of width 2^N_IN. Bit k is the required Y for vector k. The default means Y=1 only for vectors 2 and 5.
- SETTLE, default 1: number of cycles a vector is held before Y is sampled; must be ≥1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- N_RESET  in  1  asynchronous, active-low reset.
- START  in  1  request a sweep; sampled only in IDLE or DONE.
- Y  in  1  DUT output under test.
- X  out  N_IN  vector driven to the DUT inputs, registered.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  high from sweep completion until the next START or reset.
- PASS  out  1  valid when DONE=1; high if no mismatches occurred.
- FAIL_COUNT  out  N_IN+1  number of mismatching vectors in the last sweep.
- FAIL_VALID  out  1  high once any mismatch has been recorded.
- FIRST_FAIL  out  N_IN  lowest vector that mismatched; meaningful only when FAIL_VALID=1.

## Operation
- The FSM has four states: IDLE, APPLY, SAMPLE, FIN.
- IDLE → APPLY when START=1.
  - On that edge: X←0, settle counter←0, FAIL_COUNT←0, FAIL_VALID←0, FIRST_FAIL←0, PASS←0, BUSY←1.
- APPLY: the settle counter increments each cycle. When the counter reaches SETTLE−1, the state goes to SAMPLE.
- SAMPLE: Y is compared against EXPECT[X] on the edge that leaves SAMPLE.
  - On a mismatch: FAIL_COUNT increments. If FAIL_VALID=0, then FIRST_FAIL←X and FAIL_VALID←1.
  - If X < 2^N_IN−1: X←X+1, settle counter←0, next state APPLY.
  - If X = 2^N_IN−1: next state FIN, BUSY←0, DONE←1, and PASS←1 if the final FAIL_COUNT (including this sample) is 0.
- FIN: all results are held and X holds its last value.
  - START=1 in FIN behaves as START in IDLE: results clear, DONE←0, and a new sweep begins.
- START while BUSY=1 is ignored. A held START does not re-trigger mid-sweep.
- FAIL_COUNT is N_IN+1 bits wide, so it cannot overflow (maximum 2^N_IN).
- Reset is asynchronous and takes effect at any point, including mid-sweep.
  - State←IDLE; X=0, BUSY=0, DONE=0, PASS=0, FAIL_COUNT=0, FAIL_VALID=0, FIRST_FAIL=0.
  - No partial results survive reset.

## Timing
- All outputs are registered and change only on the rising edge of CLK, except on reset assertion.
- The edge that samples START is edge 0. X=0 is visible after edge 0.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in APPLY, then 1 cycle in SAMPLE.
- Y is sampled at the end of the SAMPLE cycle, so the DUT sees a stable X for SETTLE+1 edges before it is checked.
- DONE rises after edge (SETTLE+1)·2^N_IN. For the defaults this is edge 16.
- BUSY falls on the same edge that DONE rises.
- PASS, FAIL_COUNT, FAIL_VALID and FIRST_FAIL are final and stable when DONE=1.
- Reset removal: the first START can be sampled on the first rising edge after N_RESET goes high.

## Test plan
1. Correct DUT (Y = (X==2)||(X==5)), defaults, START pulse. Required:
   - X steps 0→7 at 2-cycle intervals.
   - DONE=1 after edge 16, with PASS=1, FAIL_COUNT=0, FAIL_VALID=0.
2. Y stuck at 0. Required: DONE after edge 16, PASS=0, FAIL_COUNT=2, FAIL_VALID=1, FIRST_FAIL=2.
3. Inverted DUT (Y = ~expected). Required: FAIL_COUNT=8, FIRST_FAIL=0, PASS=0.
4. SETTLE=3 with the correct DUT. Required:
   - Each X value is held 4 cycles.
   - DONE after edge 32, PASS=1.
5. START re-pulsed while BUSY, then N_RESET driven low while X=4. Required:
   - The re-pulse has no effect on the sweep.
   - On reset, all outputs go to 0 immediately and the FSM returns to IDLE.
   - A new START then completes a full, clean sweep.
6. Y stuck at 1, then START again from FIN with a correct DUT. Required:
   - First sweep: FAIL_COUNT=6, FIRST_FAIL=0.
   - On restart: results clear on the START edge, DONE drops, and the second sweep ends with PASS=1, FAIL_COUNT=0.
